tim_apb_arbiter: RTL and testbench

TIM_APB_ARBITER -- requirements
Module: tim_apb_arbiter

---
 rtl/tim_apb_arbiter.sv | 149 ++++++++++++++
 tb/tb_tim_apb_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tim_apb_arbiter.sv
// tim_apb_arbiter: two-requester round-robin front end driving the timer APB slave.
// Optional ACCESS-phase timeout abort is built when TIM_ARB_TIMEOUT_EN is defined.

module tim_apb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [23:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strb,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [11:0] tim_paddr,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready,
  input  logic        tim_pslverr
);

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("tim_apb_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t         state;
  logic           last_grant;
  logic           owner;
  logic           grant_any;
  logic           grant_idx;
  logic [1:0]     grant;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic [SW-1:0]  sel_strb;
  logic           sel_write;

`ifdef TIM_ARB_TIMEOUT_EN
  localparam int unsigned TW = 8;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_next;
  assign tmo_next = tmo_cnt + TW'(1);
`endif

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_any = |req_valid;
    grant_idx = (&req_valid) ? ~last_grant : req_valid[1];
    grant     = 2'b00;
    if (grant_any) grant[grant_idx] = 1'b1;
    sel_addr  = grant_idx ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
    sel_wdata = grant_idx ? req_wdata[2*DW-1:DW]  : req_wdata[DW-1:0];
    sel_strb  = grant_idx ? req_strb[2*SW-1:SW]   : req_strb[SW-1:0];
    sel_write = grant_idx ? req_write[1]          : req_write[0];
  end

  // Accept is combinational so a grant can share the cycle with the previous rsp_valid.
  assign req_ready = (state == IDLE && sys_rst_n) ? grant : 2'b00;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
      tim_pstrb   <= '0;
      rsp_valid   <= 2'b00;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
`ifdef TIM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner       <= grant_idx;
            last_grant  <= grant_idx;
            tim_pwrite  <= sel_write;
            tim_paddr   <= sel_addr;
            tim_pwdata  <= sel_wdata;
            tim_pstrb   <= sel_strb;
            tim_psel    <= 1'b1;
            tim_penable <= 1'b0;
            state       <= SETUP;
`ifdef TIM_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        SETUP: begin
          tim_penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (tim_pready) begin
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            state       <= IDLE;
            rsp_valid   <= owner ? 2'b10 : 2'b01;
            rsp_err     <= tim_pslverr;
            rsp_rdata   <= tim_pwrite ? '0 : tim_prdata;
          end
`ifdef TIM_ARB_TIMEOUT_EN
          else begin
            // Abort a stuck slave once the wait reaches the configured limit.
            tmo_cnt <= tmo_next;
            if (tmo_next == TW'(TIMEOUT_CYCLES)) begin
              tim_psel    <= 1'b0;
              tim_penable <= 1'b0;
              state       <= IDLE;
              rsp_valid   <= owner ? 2'b10 : 2'b01;
              rsp_err     <= 1'b1;
              rsp_rdata   <= '0;
            end
          end
`endif
        end
        default: begin
          tim_psel    <= 1'b0;
          tim_penable <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tim_apb_arbiter.sv
// Directed self-checking bench for tim_apb_arbiter with a behavioural timer APB slave.

module tb_tim_apb_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [23:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_strb = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        tim_psel, tim_penable, tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata;
  logic        tim_pready;
  logic        tim_pslverr;

  int checks = 0;
  int errors = 0;

  int          wait_cycles = 1;
  int          acc_cnt;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;

  always #5 sys_clk = ~sys_clk;

  tim_apb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .tim_psel    (tim_psel),
    .tim_penable (tim_penable),
    .tim_pwrite  (tim_pwrite),
    .tim_paddr   (tim_paddr),
    .tim_pwdata  (tim_pwdata),
    .tim_pstrb   (tim_pstrb),
    .tim_prdata  (tim_prdata),
    .tim_pready  (tim_pready),
    .tim_pslverr (tim_pslverr)
  );

  // Slave raises pready after wait_cycles ACCESS edges; junk on data/err while not ready.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tim_pready <= 1'b0;
      acc_cnt    <= 0;
    end else if (tim_psel && tim_penable && !tim_pready) begin
      if (acc_cnt == wait_cycles - 1) tim_pready <= 1'b1;
      else acc_cnt <= acc_cnt + 1;
    end else begin
      tim_pready <= 1'b0;
      acc_cnt    <= 0;
    end
  end

  assign tim_prdata  = tim_pready ? slv_rdata : 32'hBAD0_BAD0;
  assign tim_pslverr = tim_pready ? slv_err : 1'b1;

  task automatic clear_req();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr  = '1;
    req_wdata = '1;
    req_strb  = '1;
    repeat (2) @(negedge sys_clk);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready got %b want 00", req_ready);
    end
    checks++;
    if ({tim_psel, tim_penable, tim_pwrite} !== 3'b000) begin
      errors++; $display("FAIL reset_apb_ctrl got %b want 000", {tim_psel, tim_penable, tim_pwrite});
    end
    checks++;
    if ({tim_paddr, tim_pwdata, tim_pstrb} !== 48'h0) begin
      errors++; $display("FAIL reset_apb_data got %h want 0", {tim_paddr, tim_pwdata, tim_pstrb});
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin
      errors++; $display("FAIL reset_rsp got valid=%b err=%b rdata=%h want 0", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_req();
    @(negedge sys_clk);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    bit found;
    prev_g = 2'b00;
    wait_cycles = 1;
    slv_rdata = 32'h0000_0AAA;
    slv_err = 1'b0;
    @(negedge sys_clk);
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {12'h020, 12'h010};
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        if (req_ready != 2'b00) found = 1'b1;
        else begin @(negedge sys_clk); #1; end
      end
      checks++;
      if (req_ready !== exp_g) begin
        errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, exp_g);
      end
      if (k > 0) begin
        checks++;
        if (rsp_valid !== prev_g) begin
          errors++; $display("FAIL rr_back_to_back%0d rsp_valid got %b want %b", k, rsp_valid, prev_g);
        end
      end
      prev_g = exp_g;
      @(negedge sys_clk);
      if (k == 3) req_valid = 2'b00;
      #1;
    end
    repeat (3) @(negedge sys_clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h0000_0AAA}) begin
      errors++; $display("FAIL rr_last_rsp got valid=%b err=%b rdata=%h want 10/0/00000aaa", rsp_valid, rsp_err, rsp_rdata);
    end
    clear_req();
    @(negedge sys_clk);
  endtask

  task automatic test_single_read();
    logic [3:0] e_psel;
    logic [3:0] e_pen;
    e_psel = 4'b0111;
    e_pen  = 4'b0110;
    wait_cycles = 1;
    slv_rdata = 32'h1234_5678;
    slv_err = 1'b0;
    @(negedge sys_clk);
    clear_req();
    req_valid = 2'b01;
    req_addr  = 24'h000_004;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rd_accept got %b want 01", req_ready);
    end
    @(negedge sys_clk);
    #1;
    for (int cy = 1; cy <= 4; cy++) begin
      checks++;
      if ({tim_psel, tim_penable} !== {e_psel[cy-1], e_pen[cy-1]}) begin
        errors++; $display("FAIL rd_phase_c%0d got %b want %b", cy, {tim_psel, tim_penable}, {e_psel[cy-1], e_pen[cy-1]});
      end
      checks++;
      if (rsp_valid !== ((cy == 4) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL rd_rsp_valid_c%0d got %b want %b", cy, rsp_valid, (cy == 4) ? 2'b01 : 2'b00);
      end
      if (cy >= 2 && cy <= 4) begin
        checks++;
        if (req_ready !== 2'b00) begin
          errors++; $display("FAIL rd_busy_ready_c%0d got %b want 00", cy, req_ready);
        end
      end
      if (cy < 4) begin
        checks++;
        if (tim_paddr !== 12'h004 || tim_pwrite !== 1'b0) begin
          errors++; $display("FAIL rd_addr_c%0d got %h/%b want 004/0", cy, tim_paddr, tim_pwrite);
        end
      end
      if (cy == 1) begin
        req_valid = 2'b10;
        req_addr  = 24'hFFF_FFF;
      end
      if (cy == 3) req_valid = 2'b00;
      if (cy < 4) begin @(negedge sys_clk); #1; end
    end
    checks++;
    if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rd_data got %h/%b want 12345678/0", rsp_rdata, rsp_err);
    end
    @(negedge sys_clk);
    #1;
    checks++;
    if (tim_psel !== 1'b0 || tim_paddr !== 12'h004) begin
      errors++; $display("FAIL rd_idle_hold got psel=%b addr=%h want 0/004", tim_psel, tim_paddr);
    end
    clear_req();
  endtask

  task automatic test_write_err();
    wait_cycles = 1;
    slv_rdata = 32'hCAFE_F00D;
    slv_err = 1'b1;
    @(negedge sys_clk);
    clear_req();
    req_valid = 2'b10;
    req_write = 2'b10;
    req_addr  = {12'h0AB, 12'h000};
    req_wdata = {32'hDEAD_BEEF, 32'h0};
    req_strb  = {4'b0011, 4'b0000};
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL wr_accept got %b want 10", req_ready);
    end
    @(negedge sys_clk);
    #1;
    for (int cy = 1; cy <= 3; cy++) begin
      checks++;
      if ({tim_pwdata, tim_pstrb, tim_pwrite, tim_paddr} !== {32'hDEAD_BEEF, 4'b0011, 1'b1, 12'h0AB}) begin
        errors++; $display("FAIL wr_fields_c%0d got %h/%b/%b/%h want deadbeef/0011/1/0ab", cy, tim_pwdata, tim_pstrb, tim_pwrite, tim_paddr);
      end
      checks++;
      if (rsp_valid !== 2'b00 || tim_psel !== 1'b1) begin
        errors++; $display("FAIL wr_busy_c%0d got rsp_valid=%b psel=%b want 00/1", cy, rsp_valid, tim_psel);
      end
      if (cy == 1) begin
        req_valid = 2'b00;
        req_wdata = '1;
        req_strb  = '1;
      end
      @(negedge sys_clk);
      #1;
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b1, 32'h0}) begin
      errors++; $display("FAIL wr_rsp got valid=%b err=%b rdata=%h want 10/1/0", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge sys_clk);
    #1;
    checks++;
    if (tim_psel !== 1'b0 || tim_pwdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_idle_hold got psel=%b wdata=%h want 0/deadbeef", tim_psel, tim_pwdata);
    end
    slv_err = 1'b0;
    clear_req();
  endtask

  task automatic test_timeout();
    int  n_acc;
    bit  done;
    n_acc = 0;
    done = 1'b0;
    wait_cycles = 20;
    slv_rdata = 32'h55AA_55AA;
    slv_err = 1'b0;
    @(negedge sys_clk);
    clear_req();
    req_valid = 2'b01;
    req_addr  = 24'h000_008;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL to_accept got %b want 01", req_ready);
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge sys_clk);
      req_valid = 2'b00;
      #1;
      if (rsp_valid != 2'b00) done = 1'b1;
      else if (tim_psel && tim_penable) n_acc++;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL to_no_rsp got none want rsp_valid within 40 cycles");
    end
`ifdef TIM_ARB_TIMEOUT_EN
    checks++;
    if (n_acc != 16) begin
      errors++; $display("FAIL to_access_cycles got %0d want 16", n_acc);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, tim_psel} !== {2'b01, 1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL to_rsp got valid=%b err=%b rdata=%h psel=%b want 01/1/0/0", rsp_valid, rsp_err, rsp_rdata, tim_psel);
    end
`else
    checks++;
    if (n_acc != 21) begin
      errors++; $display("FAIL to_access_cycles got %0d want 21", n_acc);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, tim_psel} !== {2'b01, 1'b0, 32'h55AA_55AA, 1'b0}) begin
      errors++; $display("FAIL to_rsp got valid=%b err=%b rdata=%h psel=%b want 01/0/55aa55aa/0", rsp_valid, rsp_err, rsp_rdata, tim_psel);
    end
`endif
    wait_cycles = 1;
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid();
    wait_cycles = 1;
    slv_rdata = 32'h1111_2222;
    slv_err = 1'b0;
    @(negedge sys_clk);
    clear_req();
    req_valid = 2'b01;
    req_addr  = 24'h000_00C;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_pre_accept got %b want 01", req_ready);
    end
    @(negedge sys_clk);
    req_valid = 2'b00;
    @(negedge sys_clk);
    #1;
    checks++;
    if ({tim_psel, tim_penable} !== 2'b11) begin
      errors++; $display("FAIL rst_pre_access got %b want 11", {tim_psel, tim_penable});
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({tim_psel, tim_penable} !== 2'b00) begin
      errors++; $display("FAIL rst_async_apb got %b want 00", {tim_psel, tim_penable});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      #1;
      checks++;
      if (rsp_valid !== 2'b00) begin
        errors++; $display("FAIL rst_no_rsp_c%0d got %b want 00", c, rsp_valid);
      end
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    req_valid = 2'b11;
    req_addr  = {12'h0EE, 12'h0DD};
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_first_grant got %b want 01", req_ready);
    end
    @(negedge sys_clk);
    req_valid = 2'b00;
    repeat (3) @(negedge sys_clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, 32'h1111_2222}) begin
      errors++; $display("FAIL rst_post_rsp got valid=%b rdata=%h want 01/11112222", rsp_valid, rsp_rdata);
    end
    clear_req();
    @(negedge sys_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_write_err();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
